// File: rtl/nand3_array_pkg.sv
// Shared definitions for the nand3_array gate-library block: the default
// operand width and the decode of what the output register does each cycle.
package nand3_array_pkg;

    // Default operand/result width when the parent does not override WIDTH.
    localparam int DEFAULT_WIDTH = 1;

    // What the registered result does on the next rising edge when not in reset.
    typedef enum logic {
        CAP_HOLD = 1'b0,  // keep the last captured result, valid flag drops
        CAP_LOAD = 1'b1   // capture the current NAND result, valid flag rises
    } cap_action_e;

    // Map the input qualifier onto a capture action.
    function automatic cap_action_e decode_action(input logic in_valid);
        return in_valid ? CAP_LOAD : CAP_HOLD;
    endfunction

endpackage : nand3_array_pkg

// File: rtl/nand3_bit.sv
// Single-bit 3-input NAND, built as a 2-level AND-then-invert so the
// structure matches the gate-library primitive it stands for.
module nand3_bit (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y
);

    logic and_ab;
    logic and_abc;

    // First level: pairwise AND, then fold in the third input.
    assign and_ab  = a & b;
    assign and_abc = and_ab & c;

    // Second level: invert; y is 0 only when all three inputs are 1.
    assign y = ~and_abc;

endmodule : nand3_bit

// File: rtl/nand3_array.sv
// WIDTH-bit bitwise 3-input NAND with a zero-latency combinational result
// and a one-cycle registered result qualified by a valid flag.
module nand3_array
    import nand3_array_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             out_valid
);

    cap_action_e      action;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] res_q;
    logic             valid_d;
    logic             valid_q;

    // One NAND primitive per bit lane forms the combinational result.
    for (genvar k = 0; k < WIDTH; k++) begin : g_lane
        nand3_bit u_bit (
            .a (i0[k]),
            .b (i1[k]),
            .c (i2[k]),
            .y (y[k])
        );
    end

    assign action = decode_action(in_valid);

    // Next-state for the result register and valid flag (reset handled in the flop).
    always_comb begin
        // NOTE: defaults first so every path assigns res_d/valid_d; a path that skips them would infer a latch.
        res_d   = res_q;
        valid_d = 1'b0;
        unique case (action)
            CAP_LOAD: begin
                res_d   = y;
                valid_d = 1'b1;
            end
            CAP_HOLD: begin
                res_d   = res_q;
                valid_d = 1'b0;
            end
            default: begin
                res_d   = res_q;
                valid_d = 1'b0;
            end
        endcase
    end

    // Result and valid flops; synchronous reset wins over a same-cycle capture.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so both flops sample pre-edge values and update together.
        if (rst) begin
            res_q   <= '1;
            valid_q <= 1'b0;
        end else begin
            res_q   <= res_d;
            valid_q <= valid_d;
        end
    end

    assign y_q       = res_q;
    assign out_valid = valid_q;

endmodule : nand3_array

// File: tb/tb_nand3_array.sv
// Self-checking bench for nand3_array: one 1-bit and one 8-bit instance,
// directed vectors followed by randomized traffic against a reference model.
module tb_nand3_array;

    logic       clk;
    logic       rst;
    logic       vld;
    logic [7:0] a8, b8, c8;
    logic       a1, b1, c1;
    logic [7:0] y8, yq8;
    logic       ov8;
    logic       y1, yq1, ov1;

    int checks = 0;
    int errors = 0;

    // Reference-model state for the registered paths.
    logic [7:0] m_yq8;
    logic       m_v8;
    logic       m_yq1;
    logic       m_v1;

    nand3_array #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (vld),
        .i0        (a8),
        .i1        (b8),
        .i2        (c8),
        .y         (y8),
        .y_q       (yq8),
        .out_valid (ov8)
    );

    nand3_array #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (vld),
        .i0        (a1),
        .i1        (b1),
        .i2        (c1),
        .y         (y1),
        .y_q       (yq1),
        .out_valid (ov1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per bit: the result is 0 exactly when all three input bits are set.
    function automatic logic [7:0] ref_nand(input logic [7:0] a, input logic [7:0] b,
                                            input logic [7:0] c);
        logic [7:0] r;
        int ones;
        for (int k = 0; k < 8; k++) begin
            ones = int'(a[k]) + int'(b[k]) + int'(c[k]);
            r[k] = (ones == 3) ? 1'b0 : 1'b1;
        end
        return r;
    endfunction

    function automatic logic ref_nand1(input logic a, input logic b, input logic c);
        logic [7:0] r;
        r = ref_nand({7'b0, a}, {7'b0, b}, {7'b0, c});
        return r[0];
    endfunction

    // Registered-path reference: reset loads all ones, valid captures, else hold.
    always @(posedge clk) begin
        if (rst) begin
            m_yq8 <= 8'hFF;
            m_yq1 <= 1'b1;
            m_v8  <= 1'b0;
            m_v1  <= 1'b0;
        end else if (vld) begin
            m_yq8 <= ref_nand(a8, b8, c8);
            m_yq1 <= ref_nand1(a1, b1, c1);
            m_v8  <= 1'b1;
            m_v1  <= 1'b1;
        end else begin
            m_v8  <= 1'b0;
            m_v1  <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Combinational outputs against the model for the current inputs.
    task automatic comb_check(input string tag);
        #1;
        check({tag, ".y8"}, y8, ref_nand(a8, b8, c8));
        check({tag, ".y1"}, {7'b0, y1}, {7'b0, ref_nand1(a1, b1, c1)});
    endtask

    // Take one rising edge and compare the registered outputs to the model.
    task automatic edge_check(input string tag);
        @(posedge clk);
        #1;
        check({tag, ".yq8"}, yq8, m_yq8);
        check({tag, ".ov8"}, {7'b0, ov8}, {7'b0, m_v8});
        check({tag, ".yq1"}, {7'b0, yq1}, {7'b0, m_yq1});
        check({tag, ".ov1"}, {7'b0, ov1}, {7'b0, m_v1});
    endtask

    task automatic drive(input logic r, input logic v, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] c);
        rst = r;
        vld = v;
        a8  = a;
        b8  = b;
        c8  = c;
        a1  = a[0];
        b1  = b[0];
        c1  = c[0];
    endtask

    initial begin
        logic [2:0] vec [7];
        logic [6:0] vec_exp;
        logic [2:0] combo;
        logic [7:0] ra, rb, rc;

        vec     = '{3'b000, 3'b010, 3'b100, 3'b001, 3'b110, 3'b011, 3'b111};
        vec_exp = 7'b1111110;

        // Reset state.
        drive(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        @(posedge clk);
        edge_check("reset");
        check("reset.yq8_lit", yq8, 8'hFF);
        check("reset.ov8_lit", {7'b0, ov8}, 8'h00);

        // 1-bit sweep of all eight input combinations, 5 ns apart.
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        for (int n = 0; n < 8; n++) begin
            combo = n[2:0];
            {a1, b1, c1} = combo;
            #1;
            check($sformatf("sweep%0d", n), {7'b0, y1}, (n == 7) ? 8'h00 : 8'h01);
            #4;
        end

        // Ordered vectors (i0,i1,i2).
        for (int n = 0; n < 7; n++) begin
            {a1, b1, c1} = vec[n];
            #1;
            check($sformatf("ordered%0d", n), {7'b0, y1}, {7'b0, vec_exp[6-n]});
            #4;
        end

        // Reset with in_valid and all-ones inputs: y reads 0, register resets.
        @(negedge clk);
        drive(1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF);
        #1;
        check("rst_valid.y8_lit", y8, 8'h00);
        check("rst_valid.y1_lit", {7'b0, y1}, 8'h00);
        edge_check("rst_valid");
        check("rst_valid.yq8_lit", yq8, 8'hFF);
        check("rst_valid.ov8_lit", {7'b0, ov8}, 8'h00);

        // 8-bit directed vector.
        @(negedge clk);
        drive(1'b0, 1'b1, 8'hFF, 8'hF0, 8'h3C);
        #1;
        check("w8.y8_lit", y8, 8'hCF);
        edge_check("w8");
        check("w8.yq8_lit", yq8, 8'hCF);
        check("w8.ov8_lit", {7'b0, ov8}, 8'h01);

        // Valid gating: capture 00, then hold it while in_valid is low.
        @(negedge clk);
        drive(1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF);
        comb_check("gate_load");
        edge_check("gate_load");
        check("gate_load.yq8_lit", yq8, 8'h00);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h12, 8'h34, 8'h56);
        comb_check("gate_hold");
        edge_check("gate_hold");
        check("gate_hold.yq8_lit", yq8, 8'h00);
        check("gate_hold.ov8_lit", {7'b0, ov8}, 8'h00);

        // Back-to-back valid cycles with no bubbles.
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 8'($urandom);
            drive(1'b0, 1'b1, ra, rb, rc);
            comb_check($sformatf("b2b%0d", n));
            edge_check($sformatf("b2b%0d", n));
            check($sformatf("b2b%0d.ov8_lit", n), {7'b0, ov8}, 8'h01);
        end

        // Randomized traffic, including occasional mid-stream resets.
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 8'($urandom);
            if ($urandom_range(0, 3) == 0) ra = 8'hFF;
            drive(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), ra, rb, rc);
            comb_check($sformatf("rnd%0d", n));
            edge_check($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_nand3_array
